// File: rtl/wb_bram_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_bram_burst
// Description : Wishbone single-port block RAM slave with classic cycles and
//               registered-feedback bursts (constant, linear, wrap-4/8/16).
//               Optional macro WB_BRAM_WRAP_EN enables wrapped-burst decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bram_burst #(
  parameter int MEM_ADR_WIDTH = 11,
  parameter int DATA_BYTES    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [31:0]             adr,
  input  logic [DATA_BYTES-1:0]   sel,
  input  logic [8*DATA_BYTES-1:0] dat_ms,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [8*DATA_BYTES-1:0] dat_sm,
  output logic                    ack
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam int AW    = MEM_ADR_WIDTH;
  localparam int BW    = $clog2(DATA_BYTES);
  localparam int DEPTH = 2 ** AW;

  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR  = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLASSIC = 2'd1,
    BURST   = 2'd2
  } state_t;

  state_t          state, state_d;
  logic            ack_q, ack_d;
  logic [AW-1:0]   rd_ptr, rd_ptr_d;
  logic [AW-1:0]   bus_idx;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wrap_mask;
  logic            load_dat;
  logic            beat;
  logic            wr_en;
  logic [DW-1:0]   mem [DEPTH];
  logic            unused_bits;

  assign bus_idx     = adr[AW+BW-1:BW];
  assign unused_bits = ^{adr, bte};

  assign beat  = cyc & stb & ack_q;
  assign ack   = beat;
  assign wr_en = beat & we;

  // Bits set in the mask advance; bits outside it are frozen (wrap window).
`ifdef WB_BRAM_WRAP_EN
  always_comb begin
    case (bte)
      2'b01:   wrap_mask = AW'(3);
      2'b10:   wrap_mask = AW'(7);
      2'b11:   wrap_mask = AW'(15);
      default: wrap_mask = '1;
    endcase
  end
`else
  assign wrap_mask = '1;
`endif

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p,
                                             input logic [AW-1:0] mask);
    logic [AW-1:0] inc;
    inc = p + AW'(1);
    return (p & ~mask) | (inc & mask);
  endfunction

  always_comb begin
    state_d  = state;
    ack_d    = ack_q;
    rd_ptr_d = rd_ptr;
    load_dat = 1'b0;
    rd_addr  = bus_idx;
    if (!cyc) begin
      state_d = IDLE;
      ack_d   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stb) begin
            load_dat = 1'b1;
            rd_ptr_d = next_ptr(bus_idx, wrap_mask);
            ack_d    = 1'b1;
            state_d  = (cti == CTI_CONST || cti == CTI_INCR) ? BURST : CLASSIC;
          end
        end
        CLASSIC: begin
          if (beat) begin
            ack_d   = 1'b0;
            state_d = IDLE;
          end
        end
        BURST: begin
          if (beat) begin
            if (cti == CTI_INCR) begin
              if (!we) begin
                load_dat = 1'b1;
                rd_addr  = rd_ptr;
                rd_ptr_d = next_ptr(rd_ptr, wrap_mask);
              end
            end else if (cti == CTI_CONST) begin
              load_dat = ~we;
            end else begin
              // End-of-burst, or any non-burst type, terminates the burst.
              ack_d   = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ack_q  <= 1'b0;
      rd_ptr <= '0;
      dat_sm <= '0;
    end else begin
      state  <= state_d;
      ack_q  <= ack_d;
      rd_ptr <= rd_ptr_d;
      if (load_dat) begin
        dat_sm <= mem[rd_addr];
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (sel[i]) begin
          mem[bus_idx][8*i +: 8] <= dat_ms[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_bram_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb_bram_burst
// Description : Self-checking bench for wb_bram_burst against a word-array
//               reference model and an arithmetic burst-address sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bram_burst;

  localparam int AW    = 11;
  localparam int DEPTH = 2 ** AW;
`ifdef WB_BRAM_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [2:0] CONST = 3'b001;
  localparam logic [2:0] INCR  = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_ms = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_sm;
  logic        ack;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [DEPTH];

  wb_bram_burst #(.MEM_ADR_WIDTH(AW), .DATA_BYTES(4)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
    .sel(sel), .dat_ms(dat_ms), .cti(cti), .bte(bte),
    .dat_sm(dat_sm), .ack(ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int next_idx(input int p, input logic [1:0] bt);
    int n;
    if (WRAP && bt != 2'b00) begin
      n = 4 << (int'(bt) - 1);
      return (p / n) * n + ((p % n) + 1) % n;
    end
    return (p + 1) % DEPTH;
  endfunction

  function automatic void model_write(input int idx, input logic [3:0] s, input logic [31:0] d);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
  endfunction

  task automatic classic(input string name, input logic wr, input int idx,
                         input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = wr; adr = 32'(idx) << 2; sel = s; dat_ms = d; cti = 3'b000; bte = 2'b00;
    #1;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s ack_t: got %b expected 0", name, ack); end
    @(posedge clk); #2;
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL %s ack_t1: got %b expected 1", name, ack); end
    rd = dat_sm;
    if (wr) model_write(idx, s, d);
    else begin
      n_cmp++;
      if (dat_sm !== model[idx]) begin
        n_err++; $display("FAIL %s data[%0h]: got %h expected %h", name, idx, dat_sm, model[idx]);
      end
    end
    @(posedge clk); #2;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s ack_t2: got %b expected 0", name, ack); end
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_burst(input string name, input int start, input int n, input logic [2:0] ctype,
                          input logic [1:0] bt, input logic wr, input int gap_at, input int gap_len,
                          input bit rand_stall, input bit rand_sel, input bit idx_data, input bit chk_len);
    int seq[$];
    int p, beat, gap, budget, t_last;
    logic [31:0] wd;
    logic [3:0]  ws;
    p = start;
    for (int k = 0; k < n; k++) begin
      seq.push_back(p);
      if (ctype == INCR) p = next_idx(p, bt);
    end
    beat = 0; gap = 0; budget = 0; t_last = -1;
    wd = idx_data ? 32'(seq[0]) : $urandom;
    ws = rand_sel ? 4'($urandom) : 4'hF;
    while (beat < n && budget < 100) begin
      @(posedge clk); #1;
      cyc = 1; stb = (gap == 0); we = wr; bte = bt;
      cti = (beat == n - 1) ? 3'b111 : ctype;
      adr = 32'(seq[beat]) << 2; dat_ms = wd; sel = ws;
      #1;
      if (budget == 0) begin
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s first_ack: got %b expected 0", name, ack); end
      end
      if (!stb) begin
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s ack_no_stb: got %b expected 0", name, ack); end
      end
      if (stb && ack === 1'b1) begin
        if (!wr) begin
          n_cmp++;
          if (dat_sm !== model[seq[beat]]) begin
            n_err++; $display("FAIL %s beat%0d[%0h]: got %h expected %h", name, beat, seq[beat], dat_sm, model[seq[beat]]);
          end
        end else model_write(seq[beat], ws, wd);
        t_last = budget;
        beat++;
        if (beat < n) begin
          wd = idx_data ? 32'(seq[beat]) : $urandom;
          ws = rand_sel ? 4'($urandom) : 4'hF;
        end
        if (beat == gap_at) gap = gap_len;
        else if (rand_stall && $urandom_range(0, 3) == 0) gap = $urandom_range(1, 2);
      end else if (gap > 0) gap--;
      budget++;
    end
    if (beat < n) begin
      n_cmp++; n_err++; $display("FAIL %s timeout: got %0d beats expected %0d", name, beat, n);
    end
    if (chk_len) begin
      n_cmp++;
      if (t_last + 1 != n + 1) begin
        n_err++; $display("FAIL %s cycles: got %0d expected %0d", name, t_last + 1, n + 1);
      end
    end
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; cti = 3'b000;
    #1;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL %s ack_after_last: got %b expected 0", name, ack); end
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; cyc = 1; stb = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0", ack); end
    n_cmp++; if (dat_sm !== 32'h0) begin n_err++; $display("FAIL reset_dat: got %h expected 0", dat_sm); end
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    n_cmp++; if (dat_sm !== 32'h0) begin n_err++; $display("FAIL post_reset_dat: got %h expected 0", dat_sm); end
  endtask

  task automatic test_fill();
    logic [31:0] rd;
    do_burst("fill_lo", 0, 32, INCR, 2'b00, 1'b1, -1, 0, 0, 0, 1, 1);
    for (int b = 0; b < 10; b++)
      do_burst("fill_mid", 'h100 + 16 * b, 16, INCR, 2'b00, 1'b1, -1, 0, 1, 0, 0, 0);
    do_burst("fill_top", DEPTH - 8, 8, INCR, 2'b00, 1'b1, -1, 0, 0, 0, 1, 0);
    classic("fill_w5", 1'b1, 5, 4'hF, 32'h11223344, rd);
  endtask

  task automatic test_classic();
    logic [31:0] rd;
    classic("cl_w5", 1'b1, 5, 4'b0011, 32'hAABBCCDD, rd);
    classic("cl_r5", 1'b0, 5, 4'hF, 32'h0, rd);
    n_cmp++; if (rd !== 32'h1122CCDD) begin n_err++; $display("FAIL cl_sel_merge: got %h expected 1122ccdd", rd); end
    for (int k = 0; k < 8; k++)
      classic("cl_rand", 1'($urandom), 'h100 + $urandom_range(0, 159), 4'($urandom), $urandom, rd);
  endtask

  task automatic test_linear_burst();
    do_burst("lin4", 'h10, 4, INCR, 2'b00, 1'b0, -1, 0, 0, 0, 0, 1);
  endtask

  task automatic test_wrap();
    do_burst("wrap4", 6, 4, INCR, 2'b01, 1'b0, -1, 0, 0, 0, 0, 1);
    do_burst("wrap8", 'h100 + $urandom_range(0, 127), 8, INCR, 2'b10, 1'b0, -1, 0, 0, 0, 0, 1);
    do_burst("wrap16", 'h100 + $urandom_range(0, 127), 8, INCR, 2'b11, 1'b0, -1, 0, 0, 0, 0, 1);
  endtask

  task automatic test_stall();
    do_burst("stall8", 'h108, 8, INCR, 2'b00, 1'b0, 2, 2, 0, 0, 0, 0);
  endtask

  task automatic test_top_wrap();
    do_burst("top", DEPTH - 1, 3, INCR, 2'b00, 1'b0, -1, 0, 0, 0, 0, 1);
  endtask

  task automatic test_const();
    logic [31:0] rd;
    int a;
    a = 'h100 + $urandom_range(0, 159);
    do_burst("const_rd", a, 5, CONST, 2'b00, 1'b0, -1, 0, 0, 0, 0, 1);
    do_burst("const_wr", a, 3, CONST, 2'b00, 1'b1, -1, 0, 0, 1, 0, 1);
    classic("const_chk", 1'b0, a, 4'hF, 32'h0, rd);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      logic wr;
      wr = 1'($urandom);
      do_burst("rand", 'h100 + $urandom_range(0, 127), $urandom_range(2, 8), INCR,
               2'($urandom), wr, -1, 0, 1, wr, 0, 0);
    end
  endtask

  task automatic test_rst_mid_burst();
    logic [31:0] rd;
    logic [31:0] nd [3];
    int base, beat, budget;
    base = 'h200;
    for (int k = 0; k < 3; k++) classic("rb_init", 1'b1, base + k, 4'hF, $urandom, rd);
    for (int k = 0; k < 3; k++) nd[k] = $urandom;
    beat = 0; budget = 0;
    while (beat < 2 && budget < 10) begin
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 1; cti = INCR; bte = 2'b00; sel = 4'hF;
      adr = 32'(base + beat) << 2; dat_ms = nd[beat];
      #1;
      if (ack === 1'b1) begin model_write(base + beat, 4'hF, nd[beat]); beat++; end
      budget++;
    end
    if (beat < 2) begin n_cmp++; n_err++; $display("FAIL rb_timeout: got %0d beats expected 2", beat); end
    @(posedge clk); #1;
    adr = 32'(base + 2) << 2; dat_ms = nd[2];
    #1; rst = 1; #1;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rb_ack_in_rst: got %b expected 0", ack); end
    @(posedge clk); #1;
    rst = 0; cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) classic("rb_read", 1'b0, base + k, 4'hF, 32'h0, rd);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_classic();
    test_linear_burst();
    test_wrap();
    test_stall();
    test_top_wrap();
    test_const();
    test_random();
    test_rst_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
